// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/response bundle between a fetch unit and the PC sequencer.
// The master issues stall/jump/branch/call/ret; the slave returns pc and status flags.
interface pc_sequencer_if #(
  parameter int AW = 6
);
  logic          stall;
  logic          jmp_valid;
  logic [AW-1:0] jmp_target;
  logic          br_valid;
  logic [AW-1:0] br_offset;
  logic          call;
  logic          ret;
  logic [AW-1:0] pc;
  logic          pc_valid;
  logic          misalign;
  logic          ras_full;
  logic          ras_empty;
  logic          ras_err;

  modport master (
    output stall, jmp_valid, jmp_target,
    output br_valid, br_offset, call, ret,
    input  pc, pc_valid, misalign,
    input  ras_full, ras_empty, ras_err
  );

  modport slave (
    input  stall, jmp_valid, jmp_target,
    input  br_valid, br_offset, call, ret,
    output pc, pc_valid, misalign,
    output ras_full, ras_empty, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with jump, branch, bubble and misalign tracking.
// Define PC_RETURN_STACK_EN to build in the call/return address stack.
module pc_sequencer #(
  parameter int AW        = 6,
  parameter int STEP      = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input logic           CLK,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam logic [AW-1:0] STEP_W = AW'(STEP);
  localparam logic [AW-1:0] MASK   = AW'(STEP - 1);
  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          mis_q, mis_d;
  logic [AW-1:0] link;
  logic [AW-1:0] br_sum;
  logic          push, pop, swap, err_set;
  logic          ret_req, ret_go;
  logic [AW-1:0] ras_top;
  logic          ras_full_w;
  logic          sel_boot, sel_ret;
  logic          sel_jmp, sel_br, sel_inc;

  assign link   = pc_q + STEP_W;
  assign br_sum = pc_q + bus.br_offset;

`ifdef PC_RETURN_STACK_EN
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] stk_q [RAS_DEPTH];
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          ras_empty_w;

  assign ras_full_w  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_empty_w = (cnt_q == '0);
  assign ras_top     = stk_q[0];
  assign ret_req     = bus.ret;
  assign ret_go      = bus.ret & ~ras_empty_w;

  // Stack as a shift register: entry 0 is the top, oldest falls off the end.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      if (push) begin
        stk_q[0] <= link;
        for (int i = 1; i < RAS_DEPTH; i++)
          stk_q[i] <= stk_q[i-1];
        if (!ras_full_w) cnt_q <= cnt_q + CW'(1);
      end else if (pop) begin
        for (int i = 0; i < RAS_DEPTH - 1; i++)
          stk_q[i] <= stk_q[i+1];
        cnt_q <= cnt_q - CW'(1);
      end else if (swap) begin
        stk_q[0] <= link;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.ras_full  = ras_full_w;
  assign bus.ras_empty = ras_empty_w;
  assign bus.ras_err   = err_q;
`else
  logic unused_ras;

  assign ras_full_w = 1'b0;
  assign ras_top    = '0;
  assign ret_req    = 1'b0;
  assign ret_go     = 1'b0;
  assign unused_ras = ^{push, pop, swap, err_set,
                        bus.call, bus.ret};

  assign bus.ras_full  = 1'b0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_err   = 1'b0;
`endif

  assign sel_boot = (state_q == ST_BOOT);
  assign sel_ret  = ~sel_boot & ret_go;
  assign sel_jmp  = ~sel_boot & ~ret_req & bus.jmp_valid;
  assign sel_br   = ~sel_boot & ~ret_req
                  & ~bus.jmp_valid & bus.br_valid;
  assign sel_inc  = ~sel_boot & ~sel_ret
                  & ~sel_jmp & ~sel_br;

  // Next-PC selection by priority; a taken redirect opens a one-cycle bubble.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    push    = 1'b0;
    pop     = 1'b0;
    swap    = 1'b0;
    err_set = 1'b0;
    if (!bus.stall) begin
      unique case (1'b1)
        sel_boot: begin
          state_d = ST_RUN;
          pc_d    = RST_PC;
          valid_d = 1'b1;
        end
        sel_ret: begin
          pc_d    = ras_top;
          valid_d = 1'b0;
          swap    = bus.call;
          pop     = ~bus.call;
        end
        sel_jmp: begin
          pc_d    = bus.jmp_target & ~MASK;
          valid_d = 1'b0;
          mis_d   = mis_q | (|(bus.jmp_target & MASK));
          push    = bus.call;
          err_set = bus.call & ras_full_w;
        end
        sel_br: begin
          pc_d    = br_sum & ~MASK;
          valid_d = 1'b0;
          mis_d   = mis_q | (|(br_sum & MASK));
          push    = bus.call;
          err_set = bus.call & ras_full_w;
        end
        sel_inc: begin
          pc_d    = link;
          valid_d = 1'b1;
          err_set = ret_req;
        end
        default: ;
      endcase
    end
  end

  // Architectural PC, bubble and sticky misalign registers.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RST_PC;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = valid_q;
  assign bus.misalign = mis_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter AW, default 6: PC width in bits, legal range 4..32.
REQ-002 Parameter STEP, default 1: increment per cycle; power of two, less than 2^AW.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset; must be a multiple of STEP.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries, legal range 2..16.
REQ-005 Port CLK, input, 1 bit: clock; all state updates on the posedge.
REQ-006 Port reset, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port stall, input, 1 bit: hold the PC; all other control inputs are ignored while high.
REQ-008 Port jmp_valid, input, 1 bit: absolute jump request.
REQ-009 Port jmp_target, input, AW bits: absolute jump target.
REQ-010 Port br_valid, input, 1 bit: PC-relative branch request.
REQ-011 Port br_offset, input, AW bits: signed two's-complement branch offset.
REQ-012 Port call, input, 1 bit: qualifies the jump or branch in the same cycle as a call.
REQ-013 Port ret, input, 1 bit: return request.
REQ-014 Port pc, output, AW bits: current program counter.
REQ-015 Port pc_valid, output, 1 bit: pc is a valid fetch address this cycle.
REQ-016 Port misalign, output, 1 bit: sticky flag, a target was not a multiple of STEP.
REQ-017 Port ras_full, output, 1 bit: return-address stack is full.
REQ-018 Port ras_empty, output, 1 bit: return-address stack is empty.
REQ-019 Port ras_err, output, 1 bit: sticky flag, stack overflow or underflow occurred.

Function
REQ-020 Next-PC priority: stall > ret > jmp_valid > br_valid > increment.
REQ-021 Stall: pc, pc_valid, flags and stack hold their values.
REQ-022 Increment: pc <= pc + STEP modulo 2^AW; wraps from 2^AW-STEP to 0 silently.
REQ-023 Jump: pc <= jmp_target with the low log2(STEP) bits cleared.
REQ-024 Branch: pc <= (pc + sign-extended br_offset) modulo 2^AW, with the low log2(STEP) bits cleared.
REQ-025 misalign is set when a taken jump target or branch result has any nonzero bits in the low log2(STEP) positions; it stays set until reset.
REQ-026 Redirect bubble: in the cycle after any taken ret, jump or branch, pc_valid is 0; it is 1 in every other non-reset, non-stalled cycle.
REQ-027 All outputs are registered; a redirect becomes visible on pc exactly one cycle after its request is sampled.

Reset
REQ-028 reset==0 at a posedge: pc <= RESET_PC, pc_valid <= 0, misalign <= 0, ras_err <= 0, stack cleared (ras_empty=1, ras_full=0).
REQ-029 Reset overrides stall and all requests; it takes effect mid-redirect and discards a pending bubble.
REQ-030 In the first posedge after reset returns high, pc <= RESET_PC and pc_valid <= 1 (RESET_PC is issued as the first fetch).

Configuration
REQ-031 Macro PC_RETURN_STACK_EN compiles the return-address stack in.
REQ-032 With the macro defined: call together with a taken jump or branch pushes pc+STEP (modulo 2^AW); call without a taken jump or branch is ignored.
REQ-033 With the macro defined: ret pops the top entry into pc.
REQ-034 With the macro defined, push when full: the oldest entry is discarded, the push succeeds and ras_err is set.
REQ-035 With the macro defined, ret when empty: behaves as an increment and sets ras_err.
REQ-036 With the macro defined, ret and call in the same cycle: ret wins the PC, and the top entry is replaced by the call link value of pc+STEP (depth unchanged).
REQ-037 Without the macro: call and ret are ignored, ras_full=0, ras_empty=1, ras_err=0 constantly, and no stack storage exists.

Verification
REQ-038 AW=6, STEP=1: release reset, run 70 cycles -> pc sequence 0,1..63,0,1..; pc_valid=1 throughout.
REQ-039 pc=10: jmp_valid=1, jmp_target=40 -> pc=40 next cycle with pc_valid=0, then 41 with pc_valid=1.
REQ-040 pc=5: br_offset=6'b111100 (-4) -> pc=1; with stall asserted on the same cycle -> pc stays 5.
REQ-041 STEP=4, AW=8: jmp_target=8'h13 -> pc=8'h10 and misalign=1, held until reset.
REQ-042 Macro defined, RAS_DEPTH=2, pc=3: call+jump to 20, call+jump to 30, ret, ret -> pc=31 then 21 then 4; a third ret -> increment with ras_err=1.
REQ-043 Mid-bubble, assert reset for one cycle -> pc=RESET_PC, pc_valid=0, flags clear; next cycle pc_valid=1.
